// File: rtl/vector_pkg.sv
// Shared vector-unit types: lane geometry, register-file select width, store FSM states.
// Pure declarations; no timing or flow-control behaviour.
package vector_pkg;

   localparam int WIDTH   = 16;
   localparam int VREG_AW = 5;

   typedef logic [WIDTH-1:0][WIDTH-1:0] vector_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STORE,
      DONE
   } vst_state_t;

endpackage

// File: rtl/vst_lane_buffer.sv
// Snapshot of one vector register: parallel load, synchronous clear, lane read by index.
// Read is combinational from sel; a load lands on the next edge; there is no backpressure.
module vst_lane_buffer #(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        load,
   input  logic [WIDTH-1:0][WIDTH-1:0] din,
   input  logic [$clog2(WIDTH)-1:0]    sel,
   output logic [WIDTH-1:0]            dout
);

   logic [WIDTH-1:0][WIDTH-1:0] lanes_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_q <= '0;
      end else if (clr) begin
         lanes_q <= '0;
      end else if (load) begin
         lanes_q <= din;
      end
   end

   assign dout = lanes_q[sel];

endmodule

// File: rtl/vector_store_unit.sv
// Snapshots one vector register and writes its lanes to memory, lane 0 first; 18 cycles start-to-done.
// Each cycle with mem_ready low during the store holds the write and adds exactly one cycle.
module vector_store_unit
   import vector_pkg::VREG_AW, vector_pkg::vst_state_t,
          vector_pkg::IDLE, vector_pkg::FETCH, vector_pkg::STORE, vector_pkg::DONE;
#(
   parameter int WIDTH = 16,
   parameter int AW    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [VREG_AW-1:0]          VS,
   input  logic [AW-1:0]               base_addr,
   output logic [VREG_AW-1:0]          RS,
   input  logic [WIDTH-1:0][WIDTH-1:0] RDV,
   output logic                        mem_we,
   output logic [AW-1:0]               mem_addr,
   output logic [WIDTH-1:0]            mem_wd,
   input  logic                        mem_ready,
   output logic                        busy,
   output logic                        done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   vst_state_t    state, state_nxt;
   logic [CW-1:0] cnt, lane_nxt;
   logic [AW-1:0] base_q;
   logic [WIDTH-1:0] lane_dat;
   logic          accept, last_acc, buf_clr, buf_load;
   logic          mem_we_nxt, busy_nxt, done_nxt;

   assign accept   = (state == STORE) && mem_ready;
   assign last_acc = accept && (cnt == LAST);
   assign lane_nxt = cnt + CW'(1);
   assign buf_clr  = (state == IDLE) && start;
   assign buf_load = (state == FETCH);

   // Buffer is read one lane ahead so the next element is registered onto mem_wd on acceptance.
   vst_lane_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk  (clk),
      .rst  (rst),
      .clr  (buf_clr),
      .load (buf_load),
      .din  (RDV),
      .sel  (lane_nxt),
      .dout (lane_dat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   state_nxt = STORE;
         STORE:   if (last_acc) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state and registered, keeping mem_ready off any output path.
   always_comb begin
      mem_we_nxt = (state_nxt == STORE);
      busy_nxt   = (state_nxt != IDLE);
      done_nxt   = (state_nxt == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         RS       <= '0;
         base_q   <= '0;
         cnt      <= '0;
         mem_addr <= '0;
         mem_wd   <= '0;
      end else begin
         mem_we <= mem_we_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  RS     <= VS;
                  base_q <= base_addr;
                  cnt    <= '0;
               end
            end
            FETCH: begin
               mem_addr <= base_q;
               mem_wd   <= RDV[0];
            end
            STORE: begin
               if (accept && !last_acc) begin
                  cnt      <= lane_nxt;
                  mem_addr <= base_q + AW'(lane_nxt);
                  mem_wd   <= lane_dat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench: each issued store pushes its 16 expected (address, element) writes taken from a
// register-file array; a negedge monitor compares every presented write, busy, RS and done timing.
module tb_vector_store_unit;

   localparam int W  = 16;
   localparam int AW = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [W-1:0]  d;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [4:0]        vs = '0;
   logic [AW-1:0]     base_addr = '0;
   logic [4:0]        rs;
   logic [W-1:0][W-1:0] rdv;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [W-1:0]      mem_wd;
   logic              mem_ready = 1'b1;
   logic              busy;
   logic              done;

   vector_pkg::vector_t rf [32];
   assign rdv = rf[rs];

   vector_store_unit #(.WIDTH(W), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .VS        (vs),
      .base_addr (base_addr),
      .RS        (rs),
      .RDV       (rdv),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Shared bookkeeping; each variable has exactly one writing process.
   int          edge_n = 0;                 // edge counter process
   wr_t         exp_q[$];                   // driver
   int          ops_issued = 0;             // driver
   int          start_edge = 0;             // driver
   int          stall_base = 0;             // driver
   logic [4:0]  exp_vs = '0;                // driver
   bit          rand_rdy = 1'b0;            // driver
   logic [AW-1:0] stall_addr = '0;          // driver
   int          stall_len = 0;              // driver
   int          hold_n = 0;                 // ready generator
   int          rd_ptr = 0;                 // monitor
   int          ops_closed = 0;             // monitor
   int          stall_total = 0;            // monitor
   int          tests = 0;                  // monitor
   int          fails = 0;                  // monitor
   bit          in_op;                      // monitor
   int          cyc;                        // monitor

   initial forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // mem_ready generator: optional scripted stall on one address, otherwise always-ready or random.
   initial forever begin
      @(posedge clk);
      #1;
      if (mem_we && mem_addr == stall_addr && hold_n < stall_len) begin
         mem_ready = 1'b0;
         hold_n++;
      end else begin
         if (!(mem_we && mem_addr == stall_addr)) hold_n = 0;
         mem_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor / scoreboard.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("rst_mem_we",   64'(mem_we),   64'(0));
         chk("rst_mem_addr", 64'(mem_addr), 64'(0));
         chk("rst_mem_wd",   64'(mem_wd),   64'(0));
         chk("rst_busy",     64'(busy),     64'(0));
         chk("rst_done",     64'(done),     64'(0));
         chk("rst_rs",       64'(rs),       64'(0));
         rd_ptr     = exp_q.size();
         ops_closed = ops_issued;
      end else begin
         in_op = (ops_issued != ops_closed);
         cyc   = edge_n - start_edge + 1;
         chk("busy", 64'(busy), 64'(in_op));
         if (in_op) chk("rs", 64'(rs), 64'(exp_vs));
         if (mem_we) begin
            if (rd_ptr >= exp_q.size()) begin
               chk("unexpected_write", 64'(mem_we), 64'(0));
            end else begin
               chk("mem_addr", 64'(mem_addr), 64'(exp_q[rd_ptr].a));
               chk("mem_wd",   64'(mem_wd),   64'(exp_q[rd_ptr].d));
               if (mem_ready) rd_ptr++;
               else stall_total++;
            end
         end
         if (done) begin
            if (!in_op) begin
               chk("spurious_done", 64'(done), 64'(0));
            end else begin
               chk("lanes_written", 64'(rd_ptr), 64'(exp_q.size()));
               chk("done_cycle", 64'(cyc), 64'(18 + stall_total - stall_base));
               ops_closed = ops_issued;
            end
         end else if (in_op && cyc > 400) begin
            chk("timeout_cycles", 64'(cyc), 64'(400));
            rd_ptr     = exp_q.size();
            ops_closed = ops_issued;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a store while the unit is idle; the expected writes are the register contents at issue.
   task automatic issue(input logic [4:0] v, input logic [AW-1:0] base);
      start     = 1'b1;
      vs        = v;
      base_addr = base;
      tick();
      start      = 1'b0;
      exp_vs     = v;
      stall_base = stall_total;
      start_edge = edge_n;
      for (int k = 0; k < W; k++) begin
         wr_t e;
         e.a = base + AW'(k);
         e.d = rf[v][k];
         exp_q.push_back(e);
      end
      ops_issued++;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (ops_closed != ops_issued && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) begin
         $display("FAIL wait_idle: store still open after %0d cycles", n);
         $fatal(1, "bench stalled");
      end
   endtask

   task automatic load_v3();
      for (int k = 0; k < W; k++) rf[3][k] = 16'hA000 + 16'(k);
   endtask

   initial begin
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < W; k++) rf[r][k] = 16'($urandom);
      load_v3();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Plain store, always ready.
      issue(5'd3, 32'h100);
      wait_idle();

      // Three-cycle stall on lane 5.
      stall_addr = 32'h105;
      stall_len  = 3;
      issue(5'd3, 32'h100);
      wait_idle();
      stall_len = 0;

      // Register rewritten mid-store must not change the stored data.
      issue(5'd3, 32'h100);
      repeat (5) tick();
      for (int k = 0; k < W; k++) rf[3][k] = 16'hCCCC;
      wait_idle();
      load_v3();

      // Second start while busy is dropped.
      issue(5'd3, 32'h200);
      repeat (4) tick();
      start     = 1'b1;
      vs        = 5'd7;
      base_addr = 32'h700;
      tick();
      start = 1'b0;
      wait_idle();
      repeat (3) tick();

      // Reset mid-store aborts, then a fresh store runs normally.
      issue(5'd3, 32'h100);
      repeat (7) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      issue(5'd3, 32'h300);
      wait_idle();

      // Address wrap past the top of memory.
      issue(5'd3, 32'hFFFF_FFFA);
      wait_idle();

      // Random registers (including v0), bases, data and ready stalls.
      rand_rdy = 1'b1;
      for (int t = 0; t < 8; t++) begin
         logic [4:0] v;
         v = (t == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         for (int k = 0; k < W; k++) rf[v][k] = 16'($urandom);
         issue(v, $urandom);
         repeat (4) tick();
         for (int k = 0; k < W; k++) rf[v][k] = 16'($urandom);
         wait_idle();
      end
      rand_rdy = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
